// File: rtl/wasm_pkg.sv
// Shared types for the WebAssembly local-variable frame machinery: value
// types, operand-stack entries, frame-stack records and the frame FSM state.
package wasm_pkg;

    localparam int unsigned LOCAL_COUNT      = 16;
    localparam int unsigned CALL_STACK_DEPTH = 8;
    localparam int unsigned LOCAL_IDX_W      = 8;

    typedef enum logic [2:0] {
        VT_I32       = 3'd0,
        VT_I64       = 3'd1,
        VT_F32       = 3'd2,
        VT_F64       = 3'd3,
        VT_V128      = 3'd4,
        VT_FUNCREF   = 3'd5,
        VT_EXTERNREF = 3'd6
    } valtype_t;

    typedef struct packed {
        valtype_t    vtype;
        logic [63:0] value;
    } stack_entry_t;

    typedef enum logic {
        LS_IDLE = 1'b0,
        LS_INIT = 1'b1
    } locals_state_t;

    // Saved caller frame: where its locals start and how many there are.
    typedef struct packed {
        logic [15:0]            base;
        logic [LOCAL_IDX_W-1:0] size;
    } frame_t;

endpackage

// File: rtl/wasm_frame_stack.sv
// LIFO of saved {base, size} frame records. Only the occupancy counter is
// reset; the record storage is plain RAM.
module wasm_frame_stack
    import wasm_pkg::*;
#(
    parameter int unsigned ENTRIES = CALL_STACK_DEPTH
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  frame_t push_data,
    input  logic   pop,
    output frame_t top,
    output logic   full,
    output logic   empty
);

    localparam int unsigned CW = $clog2(ENTRIES + 1);
    localparam int unsigned IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    frame_t          entries_q [ENTRIES];
    logic [CW-1:0]   count_q, count_d;
    logic [IW-1:0]   top_ptr;

    // Occupancy update and top-of-stack view.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        count_d = count_q;
        full    = (count_q == CW'(ENTRIES));
        empty   = (count_q == '0);
        top_ptr = IW'(count_q - CW'(1));
        if (push && !full) begin
            count_d = count_q + CW'(1);
        end else if (pop && !empty) begin
            count_d = count_q - CW'(1);
        end
        top = empty ? '0 : entries_q[top_ptr];
    end

    // Occupancy counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Record storage write.
    always_ff @(posedge clk) begin
        // NOTE: storage arrays are deliberately left out of reset so they map onto RAM; validity comes from the counter.
        if (push && !full) begin
            entries_q[IW'(count_q)] <= push_data;
        end
    end

endmodule

// File: rtl/wasm_local_frames.sv
// Local-variable frame manager: allocates a frame of typed, zeroed slots on
// push (initialising INIT_LANES slots per cycle), restores the caller frame
// on pop, and gives frame-relative read/write access with sticky error flags.
module wasm_local_frames
    import wasm_pkg::*;
#(
    parameter int unsigned DEPTH      = LOCAL_COUNT * CALL_STACK_DEPTH,
    parameter int unsigned MAX_FRAMES = CALL_STACK_DEPTH,
    parameter int unsigned NUM_RD     = 2,
    parameter int unsigned INIT_LANES = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               push_valid,
    output logic                               push_ready,
    input  logic [LOCAL_IDX_W-1:0]             push_count,
    output logic [LOCAL_IDX_W-1:0]             init_type_idx,
    input  valtype_t                           init_types [INIT_LANES],
    input  logic                               pop_valid,
    output logic                               pop_ready,
    input  logic [NUM_RD-1:0]                  rd_en,
    input  logic [LOCAL_IDX_W-1:0]             rd_idx [NUM_RD],
    output stack_entry_t                       rd_data [NUM_RD],
    output logic [NUM_RD-1:0]                  rd_valid,
    input  logic                               wr_en,
    input  logic [LOCAL_IDX_W-1:0]             wr_idx,
    input  stack_entry_t                       wr_data,
    output logic [15:0]                        frame_base,
    output logic [LOCAL_IDX_W-1:0]             frame_size,
    output logic [$clog2(MAX_FRAMES+1)-1:0]    frame_depth,
    output logic                               busy,
    output logic                               overflow_err,
    output logic                               underflow_err,
    output logic                               oob_err
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned DW = $clog2(MAX_FRAMES + 1);

    locals_state_t          state_q, state_d;
    logic [15:0]            frame_base_q, frame_base_d;
    logic [LOCAL_IDX_W-1:0] frame_size_q, frame_size_d;
    logic [DW-1:0]          frame_depth_q, frame_depth_d;
    logic [LOCAL_IDX_W-1:0] init_idx_q, init_idx_d;
    logic [15:0]            pend_base_q, pend_base_d;
    logic [LOCAL_IDX_W-1:0] pend_size_q, pend_size_d;
    logic                   ovf_q, ovf_d, udf_q, udf_d, oob_q, oob_d;

    stack_entry_t           slots [DEPTH];

    logic                   push_fire, pop_fire, push_ovf, init_last, wr_legal;
    logic [16:0]            next_base, push_end;
    logic [LOCAL_IDX_W-1:0] init_remaining;
    logic                   stk_push, stk_pop, stk_full, stk_empty;
    frame_t                 stk_top;

    wasm_frame_stack #(.ENTRIES(MAX_FRAMES)) u_frame_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (stk_push),
        .push_data ('{base: frame_base_q, size: frame_size_q}),
        .pop       (stk_pop),
        .top       (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    // Handshakes and 17-bit address arithmetic so base+count cannot wrap.
    always_comb begin
        push_ready     = (state_q == LS_IDLE) && !pop_valid;
        pop_ready      = (state_q == LS_IDLE);
        push_fire      = push_valid && push_ready;
        pop_fire       = pop_valid && pop_ready;
        next_base      = 17'(frame_base_q) + 17'(frame_size_q);
        push_end       = next_base + 17'(push_count);
        push_ovf       = stk_full || (push_end > 17'(DEPTH));
        init_remaining = pend_size_q - init_idx_q;
        init_last      = (9'(init_remaining) <= 9'(INIT_LANES));
        wr_legal       = (state_q == LS_IDLE) && wr_en && (wr_idx < frame_size_q);
    end

    // FSM next state: a legal non-empty push enters INIT until the last beat.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LS_IDLE: if (push_fire && !push_ovf && (push_count != '0)) state_d = LS_INIT;
            LS_INIT: if (init_last) state_d = LS_IDLE;
        endcase
    end

    // Frame bookkeeping, frame-stack control and sticky error flags.
    always_comb begin
        frame_base_d  = frame_base_q;
        frame_size_d  = frame_size_q;
        frame_depth_d = frame_depth_q;
        init_idx_d    = init_idx_q;
        pend_base_d   = pend_base_q;
        pend_size_d   = pend_size_q;
        ovf_d         = ovf_q;
        udf_d         = udf_q;
        oob_d         = oob_q;
        stk_push      = 1'b0;
        stk_pop       = 1'b0;
        unique case (state_q)
            LS_IDLE: begin
                if (pop_fire) begin
                    if (stk_empty) begin
                        udf_d = 1'b1;
                    end else begin
                        stk_pop       = 1'b1;
                        frame_base_d  = stk_top.base;
                        frame_size_d  = stk_top.size;
                        frame_depth_d = frame_depth_q - DW'(1);
                    end
                end else if (push_fire) begin
                    if (push_ovf) begin
                        ovf_d = 1'b1;
                    end else begin
                        stk_push    = 1'b1;
                        pend_base_d = next_base[15:0];
                        pend_size_d = push_count;
                        init_idx_d  = '0;
                        if (push_count == '0) begin
                            frame_base_d  = next_base[15:0];
                            frame_size_d  = '0;
                            frame_depth_d = frame_depth_q + DW'(1);
                        end
                    end
                end
            end
            LS_INIT: begin
                init_idx_d = init_idx_q + LOCAL_IDX_W'(INIT_LANES);
                if (init_last) begin
                    frame_base_d  = pend_base_q;
                    frame_size_d  = pend_size_q;
                    frame_depth_d = frame_depth_q + DW'(1);
                    init_idx_d    = '0;
                end
            end
        endcase
        if (wr_en && !wr_legal) oob_d = 1'b1;
        for (int p = 0; p < NUM_RD; p++) begin
            if (rd_en[p] && (state_q == LS_IDLE) && (rd_idx[p] >= frame_size_q)) oob_d = 1'b1;
        end
    end

    // FSM outputs and combinational frame-relative reads (old data on same-cycle write).
    always_comb begin
        busy = (state_q == LS_INIT);
        for (int p = 0; p < NUM_RD; p++) begin
            rd_valid[p] = rd_en[p] && (state_q == LS_IDLE) && (rd_idx[p] < frame_size_q);
            rd_data[p]  = rd_valid[p] ? slots[AW'(frame_base_q) + AW'(rd_idx[p])] : '0;
        end
    end

    // State and control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= LS_IDLE;
            frame_base_q  <= '0;
            frame_size_q  <= '0;
            frame_depth_q <= '0;
            init_idx_q    <= '0;
            pend_base_q   <= '0;
            pend_size_q   <= '0;
            ovf_q         <= 1'b0;
            udf_q         <= 1'b0;
            oob_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            frame_base_q  <= frame_base_d;
            frame_size_q  <= frame_size_d;
            frame_depth_q <= frame_depth_d;
            init_idx_q    <= init_idx_d;
            pend_base_q   <= pend_base_d;
            pend_size_q   <= pend_size_d;
            ovf_q         <= ovf_d;
            udf_q         <= udf_d;
            oob_q         <= oob_d;
        end
    end

    // Slot storage: INIT lanes fill the pending frame, otherwise the user write port.
    always_ff @(posedge clk) begin
        if (state_q == LS_INIT) begin
            for (int l = 0; l < INIT_LANES; l++) begin
                if (LOCAL_IDX_W'(l) < init_remaining) begin
                    slots[AW'(pend_base_q) + AW'(init_idx_q) + AW'(l)] <= '{vtype: init_types[l], value: '0};
                end
            end
        end else if (wr_legal) begin
            slots[AW'(frame_base_q) + AW'(wr_idx)] <= wr_data;
        end
    end

    assign init_type_idx = init_idx_q;
    assign frame_base    = frame_base_q;
    assign frame_size    = frame_size_q;
    assign frame_depth   = frame_depth_q;
    assign overflow_err  = ovf_q;
    assign underflow_err = udf_q;
    assign oob_err       = oob_q;

endmodule

// File: tb/tb_wasm_local_frames.sv
// Self-checking bench for wasm_local_frames: table-driven reads of a fresh
// frame, a read scoreboard, and hand-written sequences for the multi-cycle
// corner cases (nesting, overflow/underflow, push/pop collision, reset in INIT).
module tb_wasm_local_frames;
    import wasm_pkg::*;

    localparam int unsigned DEPTH      = 128;
    localparam int unsigned MAX_FRAMES = 8;
    localparam int unsigned NUM_RD     = 2;
    localparam int unsigned INIT_LANES = 4;
    localparam int unsigned DW         = $clog2(MAX_FRAMES + 1);

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                push_valid = 1'b0;
    logic                push_ready;
    logic [7:0]          push_count = '0;
    logic [7:0]          init_type_idx;
    valtype_t            init_types [INIT_LANES];
    logic                pop_valid = 1'b0;
    logic                pop_ready;
    logic [NUM_RD-1:0]   rd_en = '0;
    logic [7:0]          rd_idx [NUM_RD];
    stack_entry_t        rd_data [NUM_RD];
    logic [NUM_RD-1:0]   rd_valid;
    logic                wr_en = 1'b0;
    logic [7:0]          wr_idx = '0;
    stack_entry_t        wr_data = '0;
    logic [15:0]         frame_base;
    logic [7:0]          frame_size;
    logic [DW-1:0]       frame_depth;
    logic                busy, overflow_err, underflow_err, oob_err;

    int n_checks = 0;
    int n_errors = 0;

    wasm_local_frames #(
        .DEPTH(DEPTH), .MAX_FRAMES(MAX_FRAMES), .NUM_RD(NUM_RD), .INIT_LANES(INIT_LANES)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .push_valid(push_valid), .push_ready(push_ready), .push_count(push_count),
        .init_type_idx(init_type_idx), .init_types(init_types),
        .pop_valid(pop_valid), .pop_ready(pop_ready),
        .rd_en(rd_en), .rd_idx(rd_idx), .rd_data(rd_data), .rd_valid(rd_valid),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
        .frame_base(frame_base), .frame_size(frame_size), .frame_depth(frame_depth),
        .busy(busy), .overflow_err(overflow_err), .underflow_err(underflow_err), .oob_err(oob_err)
    );

    always #5 clk = ~clk;

    // Slot i of a new frame gets type I32, I64, F32, F64 repeating.
    function automatic valtype_t type_for(input int i);
        case (i % 4)
            0:       return VT_I32;
            1:       return VT_I64;
            2:       return VT_F32;
            default: return VT_F64;
        endcase
    endfunction

    function automatic stack_entry_t ent(input valtype_t t, input logic [63:0] v);
        return '{vtype: t, value: v};
    endfunction

    always_comb begin
        for (int l = 0; l < INIT_LANES; l++) init_types[l] = type_for(int'(init_type_idx) + l);
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input string name, input int base, input int size, input int depth);
        check({name, "_base"},  128'(frame_base),  128'(base));
        check({name, "_size"},  128'(frame_size),  128'(size));
        check({name, "_depth"}, 128'(frame_depth), 128'(depth));
    endtask

    task automatic push_frame(input logic [7:0] cnt);
        push_valid = 1'b1;
        push_count = cnt;
        step();
        push_valid = 1'b0;
        push_count = '0;
    endtask

    task automatic pop_frame();
        pop_valid = 1'b1;
        step();
        pop_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget, output int cycles);
        cycles = 0;
        while (busy && cycles < budget) begin
            step();
            cycles++;
        end
        if (busy) check({name, "_timeout"}, 128'(busy), 128'(0));
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    // Read scoreboard: expectation queued when a read is driven, popped when sampled.
    typedef struct {
        int           port;
        logic         valid;
        stack_entry_t data;
        string        name;
    } rd_exp_t;
    rd_exp_t sb_q[$];

    task automatic rd_issue(input int p, input logic en, input logic [7:0] idx,
                            input logic v, input stack_entry_t d, input string name);
        rd_en[p]  = en;
        rd_idx[p] = idx;
        sb_q.push_back('{port: p, valid: v, data: d, name: name});
    endtask

    task automatic rd_check();
        rd_exp_t e;
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({e.name, "_valid"}, 128'(rd_valid[e.port]), 128'(e.valid));
            check({e.name, "_data"},  128'(rd_data[e.port]),  128'(e.data));
        end
    endtask

    typedef struct {
        logic         en0;
        logic [7:0]   idx0;
        logic         en1;
        logic [7:0]   idx1;
        logic         v0;
        stack_entry_t d0;
        logic         v1;
        stack_entry_t d1;
    } rd_vec_t;
    rd_vec_t vecs [5];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        stack_entry_t exp_e;

        vecs[0] = '{1'b1, 8'd0, 1'b1, 8'd1, 1'b1, ent(VT_I32, 0), 1'b1, ent(VT_I64, 0)};
        vecs[1] = '{1'b1, 8'd2, 1'b1, 8'd3, 1'b1, ent(VT_F32, 0), 1'b1, ent(VT_F64, 0)};
        vecs[2] = '{1'b1, 8'd4, 1'b1, 8'd5, 1'b1, ent(VT_I32, 0), 1'b1, ent(VT_I64, 0)};
        vecs[3] = '{1'b0, 8'd0, 1'b1, 8'd0, 1'b0, '0,             1'b1, ent(VT_I32, 0)};
        vecs[4] = '{1'b1, 8'd5, 1'b0, 8'd3, 1'b1, ent(VT_I64, 0), 1'b0, '0};
        for (int p = 0; p < NUM_RD; p++) rd_idx[p] = '0;

        // Reset state.
        step();
        step();
        rst_n = 1'b1;
        check_frame("rst", 0, 0, 0);
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_errs", 128'({overflow_err, underflow_err, oob_err}), 128'(0));
        check("rst_init_idx", 128'(init_type_idx), 128'(0));
        check("rst_push_ready", 128'(push_ready), 128'(1));
        check("rst_pop_ready", 128'(pop_ready), 128'(1));

        // Push 6 slots: two INIT beats, then frame {0,6} is current.
        push_frame(8'd6);
        check("init1_busy", 128'(busy), 128'(1));
        check("init1_idx", 128'(init_type_idx), 128'(0));
        check("init1_push_ready", 128'(push_ready), 128'(0));
        rd_issue(0, 1'b1, 8'd0, 1'b0, '0, "init_rd");
        rd_check();
        rd_en = '0;
        step();
        check("init2_busy", 128'(busy), 128'(1));
        check("init2_idx", 128'(init_type_idx), 128'(4));
        step();
        check("init_done_busy", 128'(busy), 128'(0));
        check_frame("f6", 0, 6, 1);
        check("init_rd_no_oob", 128'(oob_err), 128'(0));

        for (int i = 0; i < 5; i++) begin
            rd_issue(0, vecs[i].en0, vecs[i].idx0, vecs[i].v0, vecs[i].d0, $sformatf("vec%0d_p0", i));
            rd_issue(1, vecs[i].en1, vecs[i].idx1, vecs[i].v1, vecs[i].d1, $sformatf("vec%0d_p1", i));
            rd_check();
            rd_en = '0;
            step();
        end
        check("vec_no_oob", 128'(oob_err), 128'(0));

        // Write idx2 with a same-cycle read: the read sees the old value.
        wr_en = 1'b1; wr_idx = 8'd2; wr_data = ent(VT_F32, 64'h1234);
        rd_issue(0, 1'b1, 8'd2, 1'b1, ent(VT_F32, 0), "raw_old");
        rd_check();
        step();
        wr_en = 1'b0;
        rd_issue(0, 1'b1, 8'd2, 1'b1, ent(VT_F32, 64'h1234), "raw_new");
        rd_check();
        rd_en = '0;

        // Nested frame of 3, then write + pop in the same cycle.
        push_frame(8'd3);
        check("f3_busy", 128'(busy), 128'(1));
        step();
        check_frame("f3", 6, 3, 2);
        rd_issue(0, 1'b1, 8'd0, 1'b1, ent(VT_I32, 0), "f3_rd0");
        rd_issue(1, 1'b1, 8'd2, 1'b1, ent(VT_F32, 0), "f3_rd2");
        rd_check();
        rd_en = '0;
        wr_en = 1'b1; wr_idx = 8'd0; wr_data = ent(VT_I64, 64'hAAAA);
        pop_valid = 1'b1;
        #1;
        check("wrpop_pop_ready", 128'(pop_ready), 128'(1));
        check("wrpop_push_ready", 128'(push_ready), 128'(0));
        step();
        wr_en = 1'b0;
        pop_valid = 1'b0;
        check_frame("popped", 0, 6, 1);
        rd_issue(0, 1'b1, 8'd2, 1'b1, ent(VT_F32, 64'h1234), "kept_rd2");
        rd_issue(1, 1'b1, 8'd0, 1'b1, ent(VT_I32, 0), "wrpop_rd0");
        rd_check();
        rd_en = '0;
        check("legal_no_oob", 128'(oob_err), 128'(0));

        // Simultaneous push and pop at depth 2: pop wins.
        push_frame(8'd2);
        wait_idle("f2", 4, n);
        check_frame("f2", 6, 2, 2);
        push_valid = 1'b1; push_count = 8'd1; pop_valid = 1'b1;
        #1;
        check("coll_push_ready", 128'(push_ready), 128'(0));
        check("coll_pop_ready", 128'(pop_ready), 128'(1));
        step();
        push_valid = 1'b0; pop_valid = 1'b0; push_count = '0;
        check_frame("coll", 0, 6, 1);
        check("coll_busy", 128'(busy), 128'(0));

        // Out-of-frame read and write.
        rd_issue(0, 1'b1, 8'd5, 1'b1, ent(VT_I64, 0), "edge_rd5");
        rd_issue(1, 1'b1, 8'd6, 1'b0, '0, "oob_rd6");
        rd_check();
        step();
        rd_en = '0;
        check("oob_rd_flag", 128'(oob_err), 128'(1));
        wr_en = 1'b1; wr_idx = 8'd6; wr_data = ent(VT_F64, 64'hDEAD);
        step();
        wr_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            exp_e = (i == 2) ? ent(VT_F32, 64'h1234) : ent(type_for(i), 0);
            rd_issue(i % 2, 1'b1, 8'(i), 1'b1, exp_e, $sformatf("post_oob_rd%0d", i));
            rd_check();
            rd_en = '0;
            step();
        end

        // Fill to MAX_FRAMES, then one more push overflows.
        for (int f = 0; f < 7; f++) begin
            push_frame(8'd1);
            wait_idle("fill", 4, n);
        end
        check_frame("full", 12, 1, 8);
        check("full_no_ovf", 128'(overflow_err), 128'(0));
        push_frame(8'd1);
        check("ovf_frames", 128'(overflow_err), 128'(1));
        check("ovf_busy", 128'(busy), 128'(0));
        check_frame("ovf", 12, 1, 8);
        pop_frame();
        check_frame("pop7", 11, 1, 7);
        for (int f = 0; f < 7; f++) pop_frame();
        check_frame("empty", 0, 0, 0);
        check("no_udf", 128'(underflow_err), 128'(0));
        pop_frame();
        check("udf", 128'(underflow_err), 128'(1));
        check_frame("udf", 0, 0, 0);

        // Reset during the second INIT beat aborts the frame.
        push_frame(8'd6);
        step();
        check("abort_idx", 128'(init_type_idx), 128'(4));
        rst_n = 1'b0;
        #1;
        check("abort_async_busy", 128'(busy), 128'(0));
        step();
        rst_n = 1'b1;
        step();
        check_frame("abort", 0, 0, 0);
        check("abort_busy", 128'(busy), 128'(0));
        check("abort_errs", 128'({overflow_err, underflow_err, oob_err}), 128'(0));

        // Slot-capacity overflow, exact fit, empty frame at the top.
        push_frame(8'd129);
        check("ovf_cap", 128'(overflow_err), 128'(1));
        check("ovf_cap_busy", 128'(busy), 128'(0));
        check_frame("ovf_cap", 0, 0, 0);
        pulse_reset();
        check("clr_ovf", 128'(overflow_err), 128'(0));
        push_frame(8'd128);
        wr_en = 1'b1; wr_idx = 8'd0; wr_data = ent(VT_I64, 64'hBEEF);
        step();
        wr_en = 1'b0;
        wait_idle("fit", 40, n);
        check("fit_cycles", 128'(n + 1), 128'(32));
        check_frame("fit", 0, 128, 1);
        check("init_wr_oob", 128'(oob_err), 128'(1));
        rd_issue(0, 1'b1, 8'd0,   1'b1, ent(VT_I32, 0), "fit_rd0");
        rd_issue(1, 1'b1, 8'd127, 1'b1, ent(VT_F64, 0), "fit_rd127");
        rd_check();
        rd_en = '0;
        push_frame(8'd0);
        check("zero_busy", 128'(busy), 128'(0));
        check_frame("zero", 128, 0, 2);
        rd_issue(0, 1'b1, 8'd0, 1'b0, '0, "zero_rd0");
        rd_check();
        rd_en = '0;
        push_frame(8'd1);
        check("ovf_fit", 128'(overflow_err), 128'(1));
        check_frame("ovf_fit", 128, 0, 2);
        pop_frame();
        check_frame("fit_pop", 0, 128, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wasm_local_frames.md
WASM_LOCAL_FRAMES -- requirements
Module: wasm_local_frames

Interface
REQ-001 Parameter DEPTH, default LOCAL_COUNT*CALL_STACK_DEPTH: total local slots.
REQ-002 Parameter MAX_FRAMES, default CALL_STACK_DEPTH: maximum live frames.
REQ-003 Parameter NUM_RD, default 2: independent read ports.
REQ-004 Parameter INIT_LANES, default 4: slots initialised per cycle.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 push_valid/push_ready  in/out  1/1  frame allocation handshake.
REQ-008 push_count  in  8  slots in the new frame (params plus locals).
REQ-009 init_type_idx  out  8  index of the first slot in the current init beat.
REQ-010 init_types  in  valtype_t[INIT_LANES]  types for slots init_type_idx..+INIT_LANES-1, valid in the same cycle.
REQ-011 pop_valid/pop_ready  in/out  1/1  frame release handshake.
REQ-012 rd_en, rd_idx, rd_data, rd_valid  in/in/out/out  [NUM_RD] x 1/8/stack_entry_t/1  combinational reads, indexed relative to the current frame.
REQ-013 wr_en, wr_idx, wr_data  in/in/in  1/8/stack_entry_t  frame-relative write.
REQ-014 frame_base, frame_size, frame_depth  out  16/8/$clog2(MAX_FRAMES+1)  current frame state.
REQ-015 busy, overflow_err, underflow_err, oob_err  out  1 each  status; all three errors are sticky.

Function
REQ-016 FSM states: IDLE and INIT.
REQ-017 push_ready=1 only in IDLE with pop_valid=0; pop_ready=1 only in IDLE. A simultaneous push and pop executes the pop.
REQ-018 On push accept: if frame_depth==MAX_FRAMES or next_base+push_count>DEPTH, set overflow_err, change nothing, stay IDLE.
- next_base = frame_base+frame_size.
REQ-019 On a legal push, save the old {frame_base, frame_size} in the frame stack.
REQ-020 On a legal push with count 0: the new frame (base next_base, size 0) is current next cycle; no INIT.
REQ-021 On a legal push with count>0, enter INIT for ceil(count/INIT_LANES) cycles.
- Each cycle writes {init_types[l], 64'h0} to slots next_base+init_type_idx+l, for lanes l < remaining.
- init_type_idx advances by INIT_LANES per cycle.
REQ-022 On the INIT→IDLE edge, frame_base=next_base, frame_size=push_count, frame_depth increments.
REQ-023 busy=1 in INIT. During INIT, rd_valid=0 on all ports, and writes are dropped with oob_err set.
REQ-024 Pop with frame_depth==0 sets underflow_err and changes nothing.
REQ-025 A legal pop restores the saved base and size on the next edge and decrements frame_depth. Slots are not cleared.
REQ-026 Read port p: rd_valid=rd_en&&IDLE&&rd_idx<frame_size, and rd_data=slot[frame_base+rd_idx]. Otherwise rd_data=0 and rd_valid=0.
REQ-027 An out-of-frame read with rd_en=1 in IDLE sets oob_err.
REQ-028 A write lands at the edge when wr_idx<frame_size; otherwise it is dropped and oob_err is set.
REQ-029 Read and write to the same slot in the same cycle: the read returns the old value.
REQ-030 Write and pop in the same cycle: the write targets the pre-pop frame.
REQ-031 Address arithmetic is 17-bit internally so base+count overflow is detected, not wrapped.

Reset
REQ-032 Reset values: FSM=IDLE, frame_base=0, frame_size=0, frame_depth=0, busy=0, all errors 0, init_type_idx=0.
REQ-033 Slot storage and the frame stack are not reset; this allows RAM inference.
REQ-034 Reset asserted mid-INIT aborts initialisation; no frame becomes current.

Structure
REQ-035 stack_entry_t and valtype_t come from wasm_pkg.
REQ-036 wasm_pkg gains the FSM enum locals_state_t and the 8-bit slot index width constant LOCAL_IDX_W.
REQ-037 The frame stack is the sub-module wasm_frame_stack: LIFO of {base, size} entries, depth MAX_FRAMES, with push/pop/full/empty.

Verification
REQ-038 Push count=6, INIT_LANES=4, types I32..F64 → INIT for 2 cycles; then frame_base=0, size=6; reads idx0..5 return type i, value 0.
REQ-039 Write idx2=0x1234, push count=3, pop → read idx2 returns 0x1234; base=0, size=6 restored; depth=1.
REQ-040 Read idx6 with size=6 → rd_valid=0, rd_data=0, oob_err=1. Write idx6 → no slot changes.
REQ-041 Fill to MAX_FRAMES, then push → overflow_err=1, depth unchanged. Pop at depth 0 → underflow_err=1.
REQ-042 push_valid and pop_valid both high at depth 2 → pop executes, push_ready=0, depth=1.
REQ-043 Assert rst_n=0 during the second INIT cycle → depth=0, base=0, busy=0 after release.
